// File: rtl/reg_bank_arbiter_pkg.sv
// Shared definitions for the MAP core register-bank arbiter: FSM state encoding,
// default dimensions and a constant-foldable ceil(log2) helper.
package reg_bank_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_ADDR_W  = 2;
    localparam int unsigned DEF_DATA_W  = 8;

    // Smallest r with 2**r >= value; usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Bus between the requesters / register bank (master) and the arbiter (slave).
// Signal directions are named from the arbiter's point of view.
interface reg_bank_arbiter_if #(
    parameter int unsigned NUM_REQ = reg_bank_arbiter_pkg::DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = reg_bank_arbiter_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W  = reg_bank_arbiter_pkg::DEF_DATA_W
);
    import reg_bank_arbiter_pkg::*;

    localparam int unsigned NUM_REG = 2 ** ADDR_W;
    localparam int unsigned ID_W    = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        iReq;
    logic [NUM_REQ-1:0]        iWrite;
    logic [NUM_REQ*ADDR_W-1:0] iAddr;
    logic [NUM_REQ*DATA_W-1:0] iData;
    logic [NUM_REQ-1:0]        oGnt;
    logic [NUM_REG-1:0]        oWR;
    logic [DATA_W-1:0]         oRegData;
    logic [NUM_REG*DATA_W-1:0] iRegData;
    logic                      oRdValid;
    logic [DATA_W-1:0]         oRdData;
    logic [ID_W-1:0]           oRdId;

    modport master (
        output iReq, iWrite, iAddr, iData, iRegData,
        input  oGnt, oWR, oRegData, oRdValid, oRdData, oRdId
    );

    modport slave (
        input  iReq, iWrite, iAddr, iData, iRegData,
        output oGnt, oWR, oRegData, oRdValid, oRdData, oRdId
    );

endinterface

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping from NUM_REQ-1 back to 0. Shared with the memory-port scheduler.
module reg_bank_arbiter_rr_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned ID_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx
);

    logic            w_found;
    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_cand;

    // Walk the requesters starting at the pointer; the first hit wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + (ID_W + 1)'(k);
            // Explicit wrap so non-power-of-two NUM_REQ works.
            if (w_sum >= (ID_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W + 1)'(NUM_REQ);
            end
            w_cand = w_sum[ID_W-1:0];
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter placing one requester at a time onto a bank of registers.
// IDLE arbitrates and captures the winner; GRANT drives the write strobe or
// samples the read data, then always returns to IDLE. All outputs registered.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input logic              CLK,
    input logic              nRST,
    reg_bank_arbiter_if.slave bus
);

    localparam int unsigned NUM_REG = 2 ** ADDR_W;
    localparam int unsigned ID_W    = clog2(NUM_REQ);

    // Per-requester and per-register views of the packed buses.
    logic [ADDR_W-1:0] w_addr [NUM_REQ];
    logic [DATA_W-1:0] w_data [NUM_REQ];
    logic [DATA_W-1:0] w_reg  [NUM_REG];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
        assign w_addr[k] = bus.iAddr[k*ADDR_W +: ADDR_W];
        assign w_data[k] = bus.iData[k*DATA_W +: DATA_W];
    end

    for (genvar k = 0; k < NUM_REG; k++) begin : g_reg
        assign w_reg[k] = bus.iRegData[k*DATA_W +: DATA_W];
    end

    state_e              r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REG-1:0]  r_wr;
    logic [DATA_W-1:0]   r_reg_data;
    logic                r_rd_valid;
    logic [DATA_W-1:0]   r_rd_data;
    logic [ID_W-1:0]     r_rd_id;

    logic [NUM_REQ-1:0]  w_win_onehot;
    logic [ID_W-1:0]     w_win_idx;
    logic [ID_W-1:0]     w_ptr_next;

    reg_bank_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req (bus.iReq),
        .i_ptr (r_ptr),
        .o_gnt (w_win_onehot),
        .o_idx (w_win_idx)
    );

    // Pointer moves to the requester just above the one being served.
    always_comb begin
        w_ptr_next = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
    end

    // FSM with capture registers and registered outputs; reset aborts any access.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= StIdle;
            r_ptr      <= '0;
            r_id       <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_gnt      <= '0;
            r_wr       <= '0;
            r_reg_data <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_id    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    // A read response lives only in the IDLE cycle after its GRANT.
                    r_rd_valid <= 1'b0;
                    if (|bus.iReq) begin
                        r_state    <= StGrant;
                        r_id       <= w_win_idx;
                        r_write    <= bus.iWrite[w_win_idx];
                        r_addr     <= w_addr[w_win_idx];
                        r_reg_data <= w_data[w_win_idx];
                        r_gnt      <= w_win_onehot;
                        if (bus.iWrite[w_win_idx]) begin
                            r_wr <= NUM_REG'(1) << w_addr[w_win_idx];
                        end
                    end
                end
                StGrant: begin
                    r_gnt   <= '0;
                    r_wr    <= '0;
                    r_ptr   <= w_ptr_next;
                    r_state <= StIdle;
                    if (!r_write) begin
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= w_reg[r_addr];
                        r_rd_id    <= r_id;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.oGnt     = r_gnt;
    assign bus.oWR      = r_wr;
    assign bus.oRegData = r_reg_data;
    assign bus.oRdValid = r_rd_valid;
    assign bus.oRdData  = r_rd_data;
    assign bus.oRdId    = r_rd_id;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with a behavioural four-entry register bank.
module tb_reg_bank_arbiter;

    logic clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    reg_bank_arbiter_if #(
        .NUM_REQ (4),
        .ADDR_W  (2),
        .DATA_W  (8)
    ) bus ();

    reg_bank_arbiter #(
        .NUM_REQ (4),
        .ADDR_W  (2),
        .DATA_W  (8)
    ) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
    );

    // Register bank model: each register loads oRegData on its WR strobe, no reset.
    logic [7:0] regs [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.oWR[i]) regs[i] <= bus.oRegData;
        end
    end

    assign bus.iRegData = {regs[3], regs[2], regs[1], regs[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {8'h0, 4'(bus.oGnt), 4'(bus.oWR), bus.oRegData, 7'h0, bus.oRdValid},
              32'h0);
        check(tag, {22'h0, bus.oRdData, bus.oRdId}, 32'h0);
    endtask

    int exp_seq [5] = '{2, 3, 0, 1, 2};

    initial begin
        // Reset held with random inputs.
        rst_n        = 1'b0;
        bus.iReq     = 4'($urandom);
        bus.iWrite   = 4'($urandom);
        bus.iAddr    = 8'($urandom);
        bus.iData    = 32'($urandom);
        tick();
        tick();
        tick();
        check_all_zero("reset_hold");

        // Release with no requests: nothing moves for 10 cycles.
        bus.iReq   = 4'b0000;
        bus.iWrite = 4'b0000;
        bus.iAddr  = 8'h00;
        bus.iData  = 32'h0;
        rst_n      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all_zero("idle_after_reset");
        end

        // Single write: requester 0 writes 0xA5 to register 2.
        bus.iReq   = 4'b0001;
        bus.iWrite = 4'b0001;
        bus.iAddr  = 8'b00_00_00_10;
        bus.iData  = 32'h0000_00A5;
        tick();
        check("wr_gnt", 32'(bus.oGnt), 32'h1);
        check("wr_strobe", 32'(bus.oWR), 32'h4);
        check("wr_data", 32'(bus.oRegData), 32'hA5);
        bus.iReq = 4'b0000;
        tick();
        check("wr_gnt_drop", 32'(bus.oGnt), 32'h0);
        check("wr_strobe_drop", 32'(bus.oWR), 32'h0);
        check("wr_reg2", 32'(regs[2]), 32'hA5);
        check("wr_no_rdvalid", 32'(bus.oRdValid), 32'h0);

        // Read back register 2 through requester 1.
        bus.iReq   = 4'b0010;
        bus.iWrite = 4'b0000;
        bus.iAddr  = 8'b00_00_10_00;
        tick();
        check("rd_gnt", 32'(bus.oGnt), 32'h2);
        check("rd_no_strobe", 32'(bus.oWR), 32'h0);
        check("rd_not_yet_valid", 32'(bus.oRdValid), 32'h0);
        bus.iReq = 4'b0000;
        tick();
        check("rd_valid", 32'(bus.oRdValid), 32'h1);
        check("rd_data", 32'(bus.oRdData), 32'hA5);
        check("rd_id", 32'(bus.oRdId), 32'h1);
        tick();
        check("rd_valid_one_cycle", 32'(bus.oRdValid), 32'h0);

        // Pointer wrap: ptr=2, requesters 0 and 1 -> 0 first, then 1.
        bus.iReq  = 4'b0011;
        bus.iAddr = 8'b00_00_10_11;
        tick();
        check("wrap_gnt0", 32'(bus.oGnt), 32'h1);
        bus.iReq = 4'b0010;
        tick();
        check("wrap_rd_id0", 32'(bus.oRdId), 32'h0);
        check("wrap_rd_data0", 32'(bus.oRdData), 32'h44);
        check("wrap_rd_valid0", 32'(bus.oRdValid), 32'h1);
        tick();
        check("wrap_gnt1", 32'(bus.oGnt), 32'h2);
        bus.iReq = 4'b0000;
        tick();
        check("wrap_rd_id1", 32'(bus.oRdId), 32'h1);
        check("wrap_rd_data1", 32'(bus.oRdData), 32'hA5);

        // Fairness: all four held; ptr=2 so grants go 2,3,0,1,2 every other cycle.
        bus.iReq  = 4'b1111;
        bus.iAddr = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("fair_gnt", 32'(bus.oGnt), 32'h1 << exp_seq[i]);
            check("fair_onehot", 32'($countones(bus.oGnt)), 32'h1);
            if (i == 4) bus.iReq = 4'b0000;
            tick();
            check("fair_gap", 32'(bus.oGnt), 32'h0);
            check("fair_rd_id", 32'(bus.oRdId), 32'(exp_seq[i]));
        end

        // Reset mid-write: ptr=3, requester 0 writes 0x3C to register 1.
        bus.iReq   = 4'b0001;
        bus.iWrite = 4'b0001;
        bus.iAddr  = 8'b00_00_00_01;
        bus.iData  = 32'h0000_003C;
        tick();
        check("rst_wr_gnt", 32'(bus.oGnt), 32'h1);
        check("rst_wr_strobe", 32'(bus.oWR), 32'h2);
        #4;
        rst_n    = 1'b0;
        bus.iReq = 4'b0000;
        #1;
        check("rst_async_gnt", 32'(bus.oGnt), 32'h0);
        check("rst_async_strobe", 32'(bus.oWR), 32'h0);
        check_all_zero("rst_async_all");
        tick();
        check("rst_reg1_kept", 32'(regs[1]), 32'h22);

        // After release, only requester 3 asks; ptr is back to 0.
        rst_n      = 1'b1;
        bus.iReq   = 4'b1000;
        bus.iWrite = 4'b0000;
        bus.iAddr  = 8'b01_00_00_00;
        tick();
        check("post_rst_gnt", 32'(bus.oGnt), 32'h8);
        bus.iReq = 4'b0000;
        tick();
        check("post_rst_rd_valid", 32'(bus.oRdValid), 32'h1);
        check("post_rst_rd_data", 32'(bus.oRdData), 32'h22);
        check("post_rst_rd_id", 32'(bus.oRdId), 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
